// File: rtl/wb_commit_unit_pkg.sv
// wb_commit_unit_pkg
//   Shared types and helpers for the writeback commit slice.
//   - INS_* : instruction-class codes. These mirror the shared insType table
//     (tools/def.v) so that this slice elaborates on its own. Do not add codes here.
//   - wr_src_e : which source owns the register-file write port this cycle.
//   - ins_writes_rf / ins_is_link : class decode helpers used by the commit stage.
package wb_commit_unit_pkg;

    localparam int INS_W = 6;

    localparam logic [INS_W-1:0] INS_RCAL_MIN   = 6'd1;
    localparam logic [INS_W-1:0] INS_RCAL_MAX   = 6'd10;
    localparam logic [INS_W-1:0] INS_SHIFT_MIN  = 6'd11;
    localparam logic [INS_W-1:0] INS_SHIFT_MAX  = 6'd16;
    localparam logic [INS_W-1:0] INS_ICAL_MIN   = 6'd17;
    localparam logic [INS_W-1:0] INS_ICAL_MAX   = 6'd25;
    localparam logic [INS_W-1:0] INS_LOAD_MIN   = 6'd26;
    localparam logic [INS_W-1:0] INS_LOAD_MAX   = 6'd30;
    localparam logic [INS_W-1:0] INS_STORE_MIN  = 6'd31;
    localparam logic [INS_W-1:0] INS_STORE_MAX  = 6'd33;
    localparam logic [INS_W-1:0] INS_BRANCH_MIN = 6'd34;
    localparam logic [INS_W-1:0] INS_BRANCH_MAX = 6'd39;
    localparam logic [INS_W-1:0] INS_J          = 6'd40;
    localparam logic [INS_W-1:0] INS_JAL        = 6'd41;
    localparam logic [INS_W-1:0] INS_JR         = 6'd42;
    localparam logic [INS_W-1:0] INS_JALR       = 6'd43;

    typedef enum logic [1:0] {
        WSRC_NONE  = 2'd0,
        WSRC_PIPE  = 2'd1,
        WSRC_QUEUE = 2'd2
    } wr_src_e;

    // RCAL..SHIFT is one contiguous range, so a single compare covers both classes.
    function automatic logic ins_writes_rf(input logic [INS_W-1:0] ins);
        return ((ins >= INS_RCAL_MIN) && (ins <= INS_SHIFT_MAX)) ||
               ((ins >= INS_LOAD_MIN) && (ins <= INS_LOAD_MAX))  ||
               ((ins >= INS_ICAL_MIN) && (ins <= INS_ICAL_MAX))  ||
               (ins == INS_JAL) || (ins == INS_JALR);
    endfunction

    function automatic logic ins_is_link(input logic [INS_W-1:0] ins);
        return (ins == INS_JAL) || (ins == INS_JALR);
    endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// wb_commit_unit_if
//   Late-result channel between a long-latency unit (mul/div) and the commit stage.
//   Transfer happens on a cycle with late_valid && late_ready.
//   Signals: late_valid, late_rd[REG_AW], late_data[DATA_W] (producer -> commit),
//            late_ready (commit -> producer).
//   Modports: master = late unit, slave = wb_commit_unit.
interface wb_commit_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    import wb_commit_unit_pkg::*;

    logic              late_valid;
    logic [REG_AW-1:0] late_rd;
    logic [DATA_W-1:0] late_data;
    logic              late_ready;

    modport master (
        output late_valid,
        output late_rd,
        output late_data,
        input  late_ready
    );

    modport slave (
        input  late_valid,
        input  late_rd,
        input  late_data,
        output late_ready
    );

endinterface

// File: rtl/wb_late_queue.sv
// wb_late_queue
//   Synchronous FIFO holding {rd, data} late results waiting for a free RF write slot.
//   Ports: clk, rst (sync, active-high), push/push_rd/push_data, pop,
//          head_rd/head_data (oldest entry), full, empty, count.
//   Optional (WB_FWD_EN): probe_rd in, probe_hit out = some queued entry targets probe_rd
//   (probe_rd of zero never hits).
//   Push while full and pop while empty are ignored. DEPTH must be a power of two
//   so the pointers wrap by plain overflow.
module wb_late_queue
    import wb_commit_unit_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  REG_AW = 5,
    parameter int  DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [REG_AW-1:0] head_rd,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
`ifdef WB_FWD_EN
    ,
    input  logic [REG_AW-1:0] probe_rd,
    output logic              probe_hit
`endif
);

    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FWD_EN
    // Slot i is live when its distance from the read pointer is below the occupancy.
    logic [PTR_W-1:0] slot_off;

    always_comb begin
        probe_hit = 1'b0;
        slot_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(slot_off) < count) && (rd_mem[i] == probe_rd) && (probe_rd != '0))
                probe_hit = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit
//   Writeback commit stage. Decodes the MEM/WB slot into a register-file write and merges
//   it with late mul/div results on the single RF write port. Pipeline writes always win;
//   late results wait in wb_late_queue and drain in idle write slots. If the queue head
//   is starved for MAX_WAIT cycles, stall_req asks the pipeline for bubbles.
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     mem_valid/insType/rd/result/linkAddr   MEM/WB slot
//     late_if (slave)                  late-result handshake (valid/rd/data/ready)
//     rf_we/rf_waddr/rf_wdata          registered RF write (one cycle after decision)
//     stall_req                        registered bubble request
//     lq_count                         late-queue occupancy
//   Optional feature macro WB_FWD_EN adds:
//     fwd_valid/fwd_rd/fwd_data        combinational copy of this cycle's winning write
//     fwd_probe_rd (in), lq_hit (out)  registered probe matched against queued rd values
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  REG_AW   = 5,
    parameter int  LQ_DEPTH = 4,
    parameter int  MAX_WAIT = 8,
    localparam int CNT_W    = $clog2(LQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [INS_W-1:0]  mem_insType,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] mem_linkAddr,
    wb_commit_unit_if.slave   late_if,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_req,
    output logic [CNT_W-1:0]  lq_count
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    input  logic [REG_AW-1:0] fwd_probe_rd,
    output logic              lq_hit
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic              pipe_wr;
    logic [DATA_W-1:0] pipe_data;
    wr_src_e           src_p0;
    logic              vld_p0;
    logic [REG_AW-1:0] wr_rd_p0;
    logic [DATA_W-1:0] wr_data_p0;

    logic              q_push;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;
    logic [REG_AW-1:0] q_head_rd;
    logic [DATA_W-1:0] q_head_data;

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;

    logic              vld_p1;
    logic [REG_AW-1:0] wr_rd_p1;
    logic [DATA_W-1:0] wr_data_p1;
    logic              stall_p1;

    // ---- p0: decode, arbitration, queue control ----
    always_comb begin
        pipe_wr   = mem_valid && ins_writes_rf(mem_insType) && (mem_rd != '0);
        pipe_data = ins_is_link(mem_insType) ? mem_linkAddr : mem_result;

        src_p0 = WSRC_NONE;
        if (pipe_wr)       src_p0 = WSRC_PIPE;
        else if (!q_empty) src_p0 = WSRC_QUEUE;

        vld_p0     = 1'b0;
        wr_rd_p0   = q_head_rd;
        wr_data_p0 = q_head_data;
        case (src_p0)
            WSRC_PIPE: begin
                vld_p0     = 1'b1;
                wr_rd_p0   = mem_rd;
                wr_data_p0 = pipe_data;
            end
            WSRC_QUEUE: vld_p0 = 1'b1;
            default:    vld_p0 = 1'b0;
        endcase
    end

    // Ready comes from the registered count only; a pop this cycle does not free a slot
    // for a push this cycle. Writes to r0 are acknowledged but never stored.
    assign late_if.late_ready = !q_full;
    assign q_push = late_if.late_valid && !q_full && (late_if.late_rd != '0);
    assign q_pop  = (src_p0 == WSRC_QUEUE);

    // Counts cycles a present head was passed over; saturates at MAX_WAIT.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (q_empty || q_pop)
            wait_cnt_nxt = '0;
        else if (wait_cnt != WAIT_W'(MAX_WAIT))
            wait_cnt_nxt = wait_cnt + 1'b1;
    end

`ifdef WB_FWD_EN
    logic [REG_AW-1:0] probe_rd_p1;

    always_ff @(posedge clk) begin
        if (rst) probe_rd_p1 <= '0;
        else     probe_rd_p1 <= fwd_probe_rd;
    end

    assign fwd_valid = vld_p0;
    assign fwd_rd    = wr_rd_p0;
    assign fwd_data  = wr_data_p0;
`endif

    wb_late_queue #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (LQ_DEPTH)
    ) u_late_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_rd   (late_if.late_rd),
        .push_data (late_if.late_data),
        .pop       (q_pop),
        .head_rd   (q_head_rd),
        .head_data (q_head_data),
        .full      (q_full),
        .empty     (q_empty),
        .count     (lq_count)
`ifdef WB_FWD_EN
        ,
        .probe_rd  (probe_rd_p1),
        .probe_hit (lq_hit)
`endif
    );

    // ---- p1: registered RF write and stall request ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            wr_rd_p1   <= '0;
            wr_data_p1 <= '0;
            wait_cnt   <= '0;
            stall_p1   <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                wr_rd_p1   <= wr_rd_p0;
                wr_data_p1 <= wr_data_p0;
            end
            wait_cnt <= wait_cnt_nxt;
            stall_p1 <= (wait_cnt_nxt == WAIT_W'(MAX_WAIT));
        end
    end

    assign rf_we     = vld_p1;
    assign rf_waddr  = wr_rd_p1;
    assign rf_wdata  = wr_data_p1;
    assign stall_req = stall_p1;

endmodule
